// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared geometry, op codes, FSM states and address helper for the frame writer
package matrix_pkg;

  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int DW   = 24;
  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int AW   = CW + RW;
  // One extra coordinate bit so off-screen positions stay representable.
  localparam int XW   = CW + 1;
  localparam int YW   = RW + 1;

  typedef enum logic [1:0] {
    OP_PIXEL = 2'b00,
    OP_RECT  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_NOP   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic [AW-1:0] pix_addr(input logic [CW-1:0] x, input logic [RW-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/frame_writer_if.sv
// rtl/frame_writer_if.sv - draw command handshake and memory write port of the frame writer
interface frame_writer_if import matrix_pkg::*; ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [XW-1:0] cmd_x0;
  logic [YW-1:0] cmd_y0;
  logic [XW-1:0] cmd_x1;
  logic [YW-1:0] cmd_y1;
  logic [DW-1:0] cmd_color;
  logic          mem_we;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_din;
  logic          busy;
  logic          done;

  modport master (
    output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    input  cmd_ready, mem_we, mem_add, mem_din, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    output cmd_ready, mem_we, mem_add, mem_din, busy, done
  );

endinterface

// File: rtl/rect_scanner.sv
// rtl/rect_scanner.sv - column-major x/y nested counter over an inclusive rectangle; FW_CLIP_EN adds clip-valid
module rect_scanner import matrix_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  input  logic [XW-1:0] xa,
  input  logic [XW-1:0] xb,
  input  logic [YW-1:0] ya,
  input  logic [YW-1:0] yb,
  output logic          last,
  output logic          next_valid,
  output logic [AW-1:0] next_add
);

  logic [XW-1:0] x_q, xb_q, next_x;
  logic [YW-1:0] y_q, ya_q, yb_q, next_y;

  always_comb begin
    next_x = x_q;
    next_y = y_q + YW'(1);
    if (y_q == yb_q) begin
      next_x = x_q + XW'(1);
      next_y = ya_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      xb_q <= '0;
      ya_q <= '0;
      yb_q <= '0;
    end else if (start) begin
      x_q  <= xa;
      y_q  <= ya;
      xb_q <= xb;
      ya_q <= ya;
      yb_q <= yb;
    end else if (step) begin
      x_q  <= next_x;
      y_q  <= next_y;
    end
  end

  assign last     = (x_q == xb_q) && (y_q == yb_q);
  assign next_add = pix_addr(next_x[CW-1:0], next_y[RW-1:0]);

`ifdef FW_CLIP_EN
  assign next_valid = ~next_x[XW-1] & ~next_y[YW-1];
`else
  assign next_valid = 1'b1;
`endif

endmodule

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - expands PIXEL/RECT/CLEAR draw commands into one frame-memory write per cycle
// Optional macro FW_CLIP_EN: clip off-screen coordinates instead of wrapping them.
module frame_writer import matrix_pkg::*; (
  input logic           clk,
  input logic           rst,
  frame_writer_if.slave bus
);

  state_t        state;
  logic          ready_q, we_q, busy_q, done_q;
  logic [AW-1:0] add_q;
  logic [DW-1:0] din_q;

  op_t           op;
  logic [XW-1:0] x0w, x1w, xa_n, xb_n;
  logic [YW-1:0] y0w, y1w, ya_n, yb_n;
  logic          first_ok, accept;
  logic          scan_last, scan_step, scan_nvalid;
  logic [AW-1:0] scan_nadd;

  assign op     = op_t'(bus.cmd_op);
  assign accept = bus.cmd_valid && ready_q;

  // Corner normalisation happens on the raw command so the scan starts on the accept edge.
  always_comb begin
    x0w = bus.cmd_x0;
    x1w = bus.cmd_x1;
    y0w = bus.cmd_y0;
    y1w = bus.cmd_y1;
`ifndef FW_CLIP_EN
    x0w[XW-1] = 1'b0;
    x1w[XW-1] = 1'b0;
    y0w[YW-1] = 1'b0;
    y1w[YW-1] = 1'b0;
`endif
    xa_n = x0w;
    xb_n = x0w;
    ya_n = y0w;
    yb_n = y0w;
    case (op)
      OP_RECT: begin
        xa_n = (x0w < x1w) ? x0w : x1w;
        xb_n = (x0w < x1w) ? x1w : x0w;
        ya_n = (y0w < y1w) ? y0w : y1w;
        yb_n = (y0w < y1w) ? y1w : y0w;
      end
      OP_CLEAR: begin
        xa_n = '0;
        xb_n = XW'(COLS - 1);
        ya_n = '0;
        yb_n = YW'(ROWS - 1);
      end
      default: ;
    endcase
`ifdef FW_CLIP_EN
    first_ok = ~xa_n[XW-1] & ~ya_n[YW-1];
`else
    first_ok = 1'b1;
`endif
  end

  assign scan_step = (state == ST_RUN) && !scan_last;

  rect_scanner u_scan (
    .clk        (clk),
    .rst        (rst),
    .start      (accept),
    .step       (scan_step),
    .xa         (xa_n),
    .xb         (xb_n),
    .ya         (ya_n),
    .yb         (yb_n),
    .last       (scan_last),
    .next_valid (scan_nvalid),
    .next_add   (scan_nadd)
  );

  // mem_add only moves on a real write so it holds its last value while mem_we is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      add_q   <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (op == OP_NOP) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state <= ST_RUN;
              din_q <= bus.cmd_color;
              we_q  <= first_ok;
              if (first_ok)
                add_q <= pix_addr(xa_n[CW-1:0], ya_n[RW-1:0]);
            end
          end
        end
        ST_RUN: begin
          if (scan_last) begin
            state  <= ST_DONE;
            we_q   <= 1'b0;
            done_q <= 1'b1;
          end else begin
            we_q <= scan_nvalid;
            if (scan_nvalid)
              add_q <= scan_nadd;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_add   = add_q;
  assign bus.mem_din   = din_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - table-driven directed bench for frame_writer, plus hold and mid-command reset sequences
module tb_frame_writer;
  import matrix_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  x0, x1;
    logic [3:0]  y0, y1;
    logic [23:0] color;
    int xa, xb, ya, yb;
    int n_wr, first_add, last_add, done_lat;
    bit hold;
  } vec_t;

  typedef struct { int cyc; int add; } wr_t;

`ifdef FW_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs [9];

  frame_writer_if bus ();

  frame_writer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input int x0, input int y0, input int x1,
                              input int y1, input logic [23:0] color, input int xa, input int xb,
                              input int ya, input int yb, input int n_wr, input int first_add,
                              input int last_add, input int done_lat, input bit hold);
    vec_t v;
    v.op = op; v.x0 = 5'(x0); v.y0 = 4'(y0); v.x1 = 5'(x1); v.y1 = 4'(y1);
    v.color = color; v.xa = xa; v.xb = xb; v.ya = ya; v.yb = yb;
    v.n_wr = n_wr; v.first_add = first_add; v.last_add = last_add;
    v.done_lat = done_lat; v.hold = hold;
    return v;
  endfunction

  // Entered on a negedge where cmd_ready is expected high; returns on the negedge of cycle done+1.
  task automatic run_cmd(input int idx, input vec_t v);
    wr_t q[$];
    int it = 0, nw = 0, seq_err = 0, busy_err = 0, rdy_err = 0, done_c = -1;
    int first_a = -1, last_a = -1;
    string p;
    p = $sformatf("v%0d_", idx);
    for (int x = v.xa; x <= v.xb; x++)
      for (int y = v.ya; y <= v.yb; y++) begin
        it++;
        if (!CLIP || (x < 16 && y < 8)) q.push_back('{it, x * 8 + y});
      end
    chk({p, "ready_before"}, 32'(bus.cmd_ready), 1);
    bus.cmd_op = v.op; bus.cmd_x0 = v.x0; bus.cmd_y0 = v.y0;
    bus.cmd_x1 = v.x1; bus.cmd_y1 = v.y1; bus.cmd_color = v.color;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!v.hold) bus.cmd_valid = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_err++;
      if (bus.cmd_ready !== 1'b0) rdy_err++;
      if (bus.mem_we === 1'b1) begin
        if (nw == 0) first_a = int'(bus.mem_add);
        last_a = int'(bus.mem_add);
        if (nw >= q.size()) seq_err++;
        else if (q[nw].cyc != c || q[nw].add != int'(bus.mem_add) || bus.mem_din !== v.color) seq_err++;
        nw++;
      end
      if (bus.done === 1'b1) begin
        done_c = c;
        break;
      end
    end
    chk({p, "done_cycle"}, 32'(done_c), 32'(v.done_lat));
    chk({p, "write_count"}, 32'(nw), 32'(v.n_wr));
    chk({p, "write_sequence_errs"}, 32'(seq_err), 0);
    chk({p, "busy_errs"}, 32'(busy_err), 0);
    chk({p, "ready_low_errs"}, 32'(rdy_err), 0);
    if (v.n_wr > 0) begin
      chk({p, "first_add"}, 32'(first_a), 32'(v.first_add));
      chk({p, "last_add"}, 32'(last_a), 32'(v.last_add));
    end
    @(negedge clk);
    chk({p, "ready_after"}, 32'(bus.cmd_ready), 1);
    chk({p, "busy_after"}, 32'(bus.busy), 0);
    chk({p, "we_after"}, 32'(bus.mem_we), 0);
  endtask

  initial begin
    int nw;
    int err;
    vec_t pix;
    vecs[0] = mk(2'b00, 3, 5, 0, 0, 24'hFF0000, 3, 3, 5, 5, 1, 29, 29, 2, 1'b0);
    vecs[1] = mk(2'b10, 0, 0, 0, 0, 24'h000000, 0, 15, 0, 7, 128, 0, 127, 129, 1'b0);
    vecs[2] = mk(2'b01, 5, 6, 4, 2, 24'h00FF00, 4, 5, 2, 6, 10, 34, 46, 11, 1'b1);
    vecs[3] = mk(2'b00, 1, 1, 0, 0, 24'h0000FF, 1, 1, 1, 1, 1, 9, 9, 2, 1'b0);
    vecs[4] = mk(2'b11, 9, 3, 2, 1, 24'h123456, 0, -1, 0, -1, 0, 0, 0, 1, 1'b0);
    vecs[5] = mk(2'b01, 7, 3, 7, 3, 24'hABCDEF, 7, 7, 3, 3, 1, 59, 59, 2, 1'b0);
`ifdef FW_CLIP_EN
    vecs[6] = mk(2'b00, 19, 10, 0, 0, 24'h0F0F0F, 19, 19, 10, 10, 0, 0, 0, 2, 1'b0);
    vecs[7] = mk(2'b01, 17, 9, 18, 10, 24'h00AA00, 17, 18, 9, 10, 0, 0, 0, 5, 1'b0);
    vecs[8] = mk(2'b01, 14, 6, 17, 9, 24'hC0FFEE, 14, 17, 6, 9, 4, 118, 127, 17, 1'b0);
`else
    vecs[6] = mk(2'b00, 19, 10, 0, 0, 24'h0F0F0F, 3, 3, 2, 2, 1, 26, 26, 2, 1'b0);
    vecs[7] = mk(2'b01, 17, 9, 18, 10, 24'h00AA00, 1, 2, 1, 2, 4, 9, 18, 5, 1'b0);
    vecs[8] = mk(2'b01, 3, 0, 2, 1, 24'hC0FFEE, 2, 3, 0, 1, 4, 16, 25, 5, 1'b0);
`endif

    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b11; bus.cmd_color = '0;
    bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_x1 = '0; bus.cmd_y1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_add", 32'(bus.mem_add), 0);
    chk("rst_din", 32'(bus.mem_din), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_cmd(i, vecs[i]);

    // Reset in the middle of a CLEAR: the write strobe must drop without waiting for a clock edge.
    bus.cmd_op = 2'b10; bus.cmd_color = 24'h123456; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    nw = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) nw++;
      if (nw == 40) break;
    end
    chk("clr_writes_before_rst", 32'(nw), 40);
    chk("clr_add_before_rst", 32'(bus.mem_add), 39);
    rst = 1'b1;
    #1;
    chk("async_rst_we", 32'(bus.mem_we), 0);
    chk("async_rst_ready", 32'(bus.cmd_ready), 1);
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_add", 32'(bus.mem_add), 0);
    @(negedge clk);
    rst = 1'b0;
    err = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_we !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) err++;
    end
    chk("post_rst_idle_errs", 32'(err), 0);
    pix = mk(2'b00, 15, 7, 0, 0, 24'h808080, 15, 15, 7, 7, 1, 127, 127, 2, 1'b0);
    run_cmd(9, pix);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
